// File: rtl/pipe_pkg.sv
// Shared constants for pipeline boundary registers: payload widths,
// the canonical bubble payload, skid-mode selectors and slot occupancy.
package pipe_pkg;

    localparam int PC_W   = 32;
    localparam int INST_W = 32;
    localparam int IFID_W = PC_W + INST_W;

    // All-zero payload doubles as the nop instruction.
    localparam logic [IFID_W-1:0] NOP = {IFID_W{1'b0}};

    localparam int SKID_OFF = 0;
    localparam int SKID_ON  = 1;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_r;

    // Count events, sticking at all-ones instead of wrapping.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (inc && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register with valid, stall, flush, optional 2-entry
// skid buffer and saturating stall/flush performance counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = IFID_W,
    parameter int SKID   = SKID_OFF,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [DATA_W-1:0] BUBBLE = {DATA_W{NOP[0]}};

    logic out_valid_s;
    logic skid_full_s;
    logic stall_inc_s;
    logic flush_inc_s;

    generate
        if (SKID == SKID_OFF) begin : g_enreg
            logic              valid_r;
            logic [DATA_W-1:0] data_r;

            // Enable register: load on out_ready, hold on stall, bubble on flush.
            always_ff @(posedge clock or negedge resetn) begin
                if (!resetn) begin
                    valid_r <= 1'b0;
                    data_r  <= BUBBLE;
                end else if (flush) begin
                    valid_r <= 1'b0;
                    data_r  <= BUBBLE;
                end else if (out_ready) begin
                    valid_r <= in_valid;
                    data_r  <= in_data;
                end else begin
                    valid_r <= valid_r;
                    data_r  <= data_r;
                end
            end

            assign in_ready    = out_ready;
            assign out_valid_s = valid_r;
            assign out_data    = data_r;
            assign skid_full_s = 1'b0;
        end else begin : g_skid
            logic              main_valid_r;
            logic              skid_valid_r;
            logic              in_ready_r;
            logic [DATA_W-1:0] main_data_r;
            logic [DATA_W-1:0] skid_data_r;
            logic              main_valid_s;
            logic              skid_valid_s;
            logic [DATA_W-1:0] main_data_s;
            logic [DATA_W-1:0] skid_data_s;
            logic              accept_s;
            logic              drain_s;
            occ_e              occ_s;

            assign accept_s = in_valid && in_ready_r;
            assign drain_s  = main_valid_r && out_ready;

            // Classify slot occupancy; skid-only is unreachable.
            always_comb begin
                case ({main_valid_r, skid_valid_r})
                    2'b00:   occ_s = OCC_EMPTY;
                    2'b10:   occ_s = OCC_ONE;
                    2'b11:   occ_s = OCC_TWO;
                    default: occ_s = OCC_EMPTY;
                endcase
            end

            // Next slot contents; main always holds the oldest entry.
            always_comb begin
                main_valid_s = main_valid_r;
                main_data_s  = main_data_r;
                skid_valid_s = skid_valid_r;
                skid_data_s  = skid_data_r;
                if (flush) begin
                    main_valid_s = 1'b0;
                    main_data_s  = BUBBLE;
                    skid_valid_s = 1'b0;
                    skid_data_s  = BUBBLE;
                end else begin
                    case (occ_s)
                        OCC_EMPTY: begin
                            if (accept_s) begin
                                main_valid_s = 1'b1;
                                main_data_s  = in_data;
                            end else begin
                                main_valid_s = 1'b0;
                            end
                        end
                        OCC_ONE: begin
                            if (drain_s && accept_s) begin
                                main_valid_s = 1'b1;
                                main_data_s  = in_data;
                            end else if (drain_s) begin
                                main_valid_s = 1'b0;
                                main_data_s  = BUBBLE;
                            end else if (accept_s) begin
                                skid_valid_s = 1'b1;
                                skid_data_s  = in_data;
                            end else begin
                                main_valid_s = 1'b1;
                            end
                        end
                        OCC_TWO: begin
                            if (drain_s) begin
                                main_data_s  = skid_data_r;
                                skid_valid_s = 1'b0;
                                skid_data_s  = BUBBLE;
                            end else begin
                                skid_valid_s = 1'b1;
                            end
                        end
                        default: begin
                            main_valid_s = 1'b0;
                            main_data_s  = BUBBLE;
                            skid_valid_s = 1'b0;
                            skid_data_s  = BUBBLE;
                        end
                    endcase
                end
            end

            // in_ready comes from the next skid state, so out_ready never reaches it combinationally.
            always_ff @(posedge clock or negedge resetn) begin
                if (!resetn) begin
                    main_valid_r <= 1'b0;
                    main_data_r  <= BUBBLE;
                    skid_valid_r <= 1'b0;
                    skid_data_r  <= BUBBLE;
                    in_ready_r   <= 1'b0;
                end else begin
                    main_valid_r <= main_valid_s;
                    main_data_r  <= main_data_s;
                    skid_valid_r <= skid_valid_s;
                    skid_data_r  <= skid_data_s;
                    in_ready_r   <= ~skid_valid_s;
                end
            end

            assign in_ready    = in_ready_r;
            assign out_valid_s = main_valid_r;
            assign out_data    = main_data_r;
            assign skid_full_s = skid_valid_r;
        end
    endgenerate

    assign out_valid   = out_valid_s;
    assign stall_inc_s = out_valid_s && !out_ready && !flush;
    assign flush_inc_s = flush && (out_valid_s || skid_full_s);

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clock  (clock),
        .resetn (resetn),
        .inc    (stall_inc_s),
        .clr    (cnt_clr),
        .cnt    (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clock  (clock),
        .resetn (resetn),
        .inc    (flush_inc_s),
        .clr    (cnt_clr),
        .cnt    (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench: one enable-register instance and one skid instance (4-bit counters).
module tb_pipe_stage_reg;

    localparam int DW   = 64;
    localparam int CW0  = 16;
    localparam int CW1  = 4;
    localparam int MAX0 = 65535;
    localparam int MAX1 = 15;
    localparam logic [63:0] PAT0 = 64'h0000_0004_2010_0001;

    logic clock = 1'b0;
    logic resetn;

    logic          a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready, a_cnt_clr;
    logic [DW-1:0] a_in_data, a_out_data;
    logic [CW0-1:0] a_stall_cnt, a_flush_cnt;

    logic          b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready, b_cnt_clr;
    logic [DW-1:0] b_in_data, b_out_data;
    logic [CW1-1:0] b_stall_cnt, b_flush_cnt;

    pipe_stage_reg #(.DATA_W(DW), .SKID(0), .CNT_W(CW0)) u_m0 (
        .clock(clock), .resetn(resetn),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .flush(a_flush),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .cnt_clr(a_cnt_clr), .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
    );

    pipe_stage_reg #(.DATA_W(DW), .SKID(1), .CNT_W(CW1)) u_m1 (
        .clock(clock), .resetn(resetn),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .flush(b_flush),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .cnt_clr(b_cnt_clr), .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
    );

    initial forever #5 clock = ~clock;

    int n_checks = 0;
    int n_err    = 0;
    int b_rx     = 0;

    // Reference state: queues of accepted-but-undelivered entries, plus counter models.
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    int          held1   = 0;
    logic        ir1_exp = 1'b0;
    logic        pf0     = 1'b1;
    logic        pf1     = 1'b1;
    int unsigned st0 = 0, fl0 = 0, st1 = 0, fl1 = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int unsigned sat(input int unsigned v, input int unsigned mx);
        return (v < mx) ? v + 1 : v;
    endfunction

    // Model: applies the stage rules at each edge and pushes accepted entries.
    initial begin : model
        logic s0, f0, s1, f1, acc1, drn1;
        forever begin
            @(posedge clock or negedge resetn);
            if (!resetn) begin
                q0.delete(); q1.delete();
                held1 = 0; ir1_exp = 1'b0; pf0 = 1'b1; pf1 = 1'b1;
                st0 = 0; fl0 = 0; st1 = 0; fl1 = 0;
            end else begin
                s0   = (q0.size() > 0) && !a_out_ready && !a_flush;
                f0   = a_flush && (q0.size() > 0);
                acc1 = b_in_valid && ir1_exp;
                drn1 = (held1 > 0) && b_out_ready;
                s1   = (held1 > 0) && !b_out_ready && !b_flush;
                f1   = b_flush && (held1 > 0);
                if (a_cnt_clr) begin st0 = 0; fl0 = 0; end
                else begin st0 = s0 ? sat(st0, MAX0) : st0; fl0 = f0 ? sat(fl0, MAX0) : fl0; end
                if (b_cnt_clr) begin st1 = 0; fl1 = 0; end
                else begin st1 = s1 ? sat(st1, MAX1) : st1; fl1 = f1 ? sat(fl1, MAX1) : fl1; end
                if (a_flush) begin
                    q0.delete(); pf0 = 1'b1;
                end else if (a_out_ready) begin
                    if (a_in_valid) q0.push_back(a_in_data);
                    pf0 = 1'b0;
                end
                if (b_flush) begin
                    q1.delete(); held1 = 0; pf1 = 1'b1;
                end else begin
                    held1 = held1 - int'(drn1) + int'(acc1);
                    if (acc1) begin q1.push_back(b_in_data); pf1 = 1'b0; end
                end
                ir1_exp = (held1 < 2);
            end
        end
    end

    // Monitor: pops an expected entry whenever the DUT hands one downstream.
    initial begin : mon_pop
        logic [DW-1:0] e;
        forever begin
            @(posedge clock);
            check("m0_in_ready_eq_out_ready", a_in_ready, a_out_ready);
            if (resetn && a_out_valid && a_out_ready && !a_flush) begin
                n_checks++;
                if (q0.size() == 0) begin
                    n_err++;
                    $display("FAIL m0_deliver: got %h expected no entry at %0t", a_out_data, $time);
                end else begin
                    n_checks--;
                    e = q0.pop_front();
                    check("m0_deliver", a_out_data, e);
                end
            end
            if (resetn && b_out_valid && b_out_ready && !b_flush) begin
                b_rx++;
                n_checks++;
                if (q1.size() == 0) begin
                    n_err++;
                    $display("FAIL m1_deliver: got %h expected no entry at %0t", b_out_data, $time);
                end else begin
                    n_checks--;
                    e = q1.pop_front();
                    check("m1_deliver", b_out_data, e);
                end
            end
        end
    end

    // Monitor: state checks mid-cycle against the model.
    initial begin : mon_state
        forever begin
            @(negedge clock);
            check("m0_out_valid", a_out_valid, q0.size() != 0);
            if (q0.size() != 0) check("m0_out_data", a_out_data, q0[0]);
            if (pf0) check("m0_bubble", a_out_data, 64'd0);
            check("m0_stall_cnt", a_stall_cnt, 64'(st0));
            check("m0_flush_cnt", a_flush_cnt, 64'(fl0));
            check("m1_out_valid", b_out_valid, held1 > 0);
            check("m1_in_ready", b_in_ready, ir1_exp);
            if (held1 > 0 && q1.size() != 0) check("m1_out_data", b_out_data, q1[0]);
            if (pf1) check("m1_bubble", b_out_data, 64'd0);
            check("m1_stall_cnt", b_stall_cnt, 64'(st1));
            check("m1_flush_cnt", b_flush_cnt, 64'(fl1));
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: bench did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int unsigned nxt;
        int          cyc;
        int          rx_base;
        resetn = 1'b0;
        a_in_valid = 1'b0; a_in_data = 64'd0; a_flush = 1'b0; a_out_ready = 1'b1; a_cnt_clr = 1'b0;
        b_in_valid = 1'b0; b_in_data = 64'd0; b_flush = 1'b0; b_out_ready = 1'b0; b_cnt_clr = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_m0_valid", a_out_valid, 1'b0);
        check("rst_m0_data", a_out_data, 64'd0);
        check("rst_m0_in_ready_hi", a_in_ready, 1'b1);
        check("rst_m1_in_ready", b_in_ready, 1'b0);
        check("rst_m1_valid", b_out_valid, 1'b0);
        a_out_ready = 1'b0;
        #1;
        check("rst_m0_in_ready_lo", a_in_ready, 1'b0);
        resetn = 1'b1;
        @(negedge clock);

        // Enable-register load then 3-cycle stall.
        a_in_valid = 1'b1; a_in_data = PAT0; a_out_ready = 1'b1;
        @(negedge clock);
        check("m0_first_load", a_out_data, PAT0);
        a_out_ready = 1'b0;
        repeat (3) begin
            a_in_data = {$urandom, $urandom};
            @(negedge clock);
        end
        check("m0_hold", a_out_data, PAT0);
        check("m0_stall3", a_stall_cnt, 64'd3);
        a_out_ready = 1'b1; a_in_valid = 1'b0;
        @(negedge clock);

        // Skid stream 1..8 with downstream stall in cycles 3-4.
        nxt = 1; rx_base = b_rx;
        for (cyc = 0; cyc < 40 && (b_rx - rx_base) < 8; cyc++) begin
            b_out_ready = !(cyc == 3 || cyc == 4);
            b_in_valid  = (nxt <= 8);
            b_in_data   = 64'(nxt);
            if (cyc == 4) check("m1_ready_drop", b_in_ready, 1'b0);
            if (cyc == 6) check("m1_ready_back", b_in_ready, 1'b1);
            @(posedge clock);
            if (b_in_valid && b_in_ready) nxt++;
            @(negedge clock);
        end
        check("m1_stream_count", 64'(b_rx - rx_base), 64'd8);
        check("m1_stream_cycles", 64'(cyc), 64'd11);
        b_in_valid = 1'b0; b_out_ready = 1'b1;
        @(negedge clock);

        // Flush with both slots full and a concurrent input handshake.
        b_out_ready = 1'b0; b_in_valid = 1'b1; b_in_data = 64'hA;
        @(negedge clock);
        b_in_data = 64'hB;
        @(negedge clock);
        check("m1_full_ready", b_in_ready, 1'b0);
        b_flush = 1'b1; b_in_data = 64'hC;
        @(negedge clock);
        b_flush = 1'b0; b_in_valid = 1'b0;
        check("m1_flush_valid", b_out_valid, 1'b0);
        check("m1_flush_data", b_out_data, 64'd0);
        check("m1_flush_ready", b_in_ready, 1'b1);
        check("m1_flush_cnt1", b_flush_cnt, 64'd1);
        b_flush = 1'b1;
        @(negedge clock);
        b_flush = 1'b0;
        check("m1_flush_empty", b_flush_cnt, 64'd1);

        // Saturation of the 4-bit stall counter, then clear during stall.
        b_in_valid = 1'b1; b_in_data = 64'hD;
        @(negedge clock);
        b_in_valid = 1'b0;
        repeat (20) @(negedge clock);
        check("m1_stall_sat", b_stall_cnt, 64'd15);
        b_cnt_clr = 1'b1;
        @(negedge clock);
        b_cnt_clr = 1'b0;
        check("m1_clr_stall", b_stall_cnt, 64'd0);
        check("m1_clr_flush", b_flush_cnt, 64'd0);
        @(negedge clock);
        check("m1_after_clr", b_stall_cnt, 64'd1);
        b_out_ready = 1'b1;
        @(negedge clock);

        // Asynchronous reset mid-stream.
        a_in_valid = 1'b1; a_in_data = 64'h1234_5678_9ABC_DEF0; a_out_ready = 1'b1;
        b_in_valid = 1'b1; b_in_data = 64'hE; b_out_ready = 1'b0;
        @(negedge clock);
        @(posedge clock);
        #2;
        resetn = 1'b0;
        #1;
        check("mid_rst_m0_valid", a_out_valid, 1'b0);
        check("mid_rst_m0_data", a_out_data, 64'd0);
        check("mid_rst_m0_stall", a_stall_cnt, 64'd0);
        check("mid_rst_m1_valid", b_out_valid, 1'b0);
        check("mid_rst_m1_data", b_out_data, 64'd0);
        check("mid_rst_m1_stall", b_stall_cnt, 64'd0);
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);

        // Random traffic on both instances.
        repeat (800) begin
            a_in_valid  = $urandom_range(0, 1) != 0;
            a_out_ready = $urandom_range(0, 3) != 0;
            a_flush     = $urandom_range(0, 19) == 0;
            a_cnt_clr   = $urandom_range(0, 49) == 0;
            a_in_data   = {$urandom, $urandom};
            b_in_valid  = $urandom_range(0, 3) != 0;
            b_out_ready = $urandom_range(0, 1) != 0;
            b_flush     = $urandom_range(0, 19) == 0;
            b_cnt_clr   = $urandom_range(0, 49) == 0;
            b_in_data   = {$urandom, $urandom};
            @(negedge clock);
        end
        a_in_valid = 1'b0; a_flush = 1'b0; a_cnt_clr = 1'b0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_flush = 1'b0; b_cnt_clr = 1'b0; b_out_ready = 1'b1;
        repeat (3) @(negedge clock);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
